// File: rtl/nonce_report_queue_pkg.sv
// nonce_report_pkg: field layout of the 360-bit MISO report word, flag bit
// positions and a packing helper shared by the report queue and its FIFO.
package nonce_report_pkg;

  localparam int         MISO_W   = 360;
  localparam int         ENT_W    = 40;
  localparam int         DIFY_W   = 32;
  localparam logic [7:0] MISO_HDR = 8'hA5;

  // Flag byte bit positions
  localparam int FLG_VALID = 0;
  localparam int FLG_OVF   = 1;
  localparam int FLG_BUSY  = 2;

  // Field LSB offsets inside the MISO word (everything below DIFY_LSB is zero)
  localparam int HDR_LSB  = 352;
  localparam int CNT_LSB  = 344;
  localparam int FLG_LSB  = 336;
  localparam int ENT_LSB  = 296;
  localparam int DIFY_LSB = 264;

  function automatic logic [MISO_W-1:0] pack_word(
    input logic [7:0]        cnt,
    input logic [7:0]        flags,
    input logic [ENT_W-1:0]  entry,
    input logic [DIFY_W-1:0] dify
  );
    logic [MISO_W-1:0] w;
    w                     = '0;
    w[HDR_LSB  +: 8]      = MISO_HDR;
    w[CNT_LSB  +: 8]      = cnt;
    w[FLG_LSB  +: 8]      = flags;
    w[ENT_LSB  +: ENT_W]  = entry;
    w[DIFY_LSB +: DIFY_W] = dify;
    return w;
  endfunction

endpackage

// File: rtl/nonce_report_queue_if.sv
// Bundle of core-side inputs, SPI chip select and report outputs of the
// nonce report queue. master = core/SPI environment, slave = the queue.
interface nonce_report_queue_if
  import nonce_report_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int ENTRY_W = 40
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               cs_n;
  logic               irq;
  logic [ENTRY_W-1:0] id_nonce_in;
  logic [DIFY_W-1:0]  hash_dify_in;
  logic               busy_in;
  logic [MISO_W-1:0]  miso_data;
  logic [CNT_W-1:0]   count;
  logic               overflow;

  modport master (
    output cs_n, irq, id_nonce_in, hash_dify_in, busy_in,
    input  miso_data, count, overflow
  );

  modport slave (
    input  cs_n, irq, id_nonce_in, hash_dify_in, busy_in,
    output miso_data, count, overflow
  );
endinterface

// File: rtl/nonce_report_queue_fifo.sv
// report_fifo: pointer/count FIFO with a combinational head view.
// Push and pop may happen in the same cycle; a push into a full FIFO only
// succeeds when a pop frees the slot in that same cycle.
module report_fifo #(
  parameter int DEPTH   = 8,
  parameter int ENTRY_W = 40
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_push,
  input  logic [ENTRY_W-1:0]       i_din,
  input  logic                     i_pop,
  output logic [ENTRY_W-1:0]       o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [AW:0]        r_count;
  logic               w_pop_ok;
  logic               w_push_ok;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);
  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/nonce_report_queue.sv
// nonce_report_queue: captures core results on rising irq into a FIFO and
// loads one entry per SPI frame (synced cs_n falling edge) into the 360-bit
// MISO word together with occupancy, flags and the difficulty echo.
// Optional feature macro: NONCE_DEDUP_EN (discard a push equal to the last
// successfully written entry).
module nonce_report_queue
  import nonce_report_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int ENTRY_W = 40
) (
  input  logic                 clk,
  input  logic                 reset_n,
  nonce_report_queue_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               r_cs_sync1, r_cs_sync2, r_cs_d;
  logic [1:0]         r_fill;
  logic               r_armed;
  logic               r_frame;
  logic               r_irq_d;
  logic               r_overflow;
  logic [MISO_W-1:0]  r_miso;

  logic               w_cs_fall;
  logic               w_irq_rise;
  logic               w_dup;
  logic               w_push_req;
  logic               w_push_ok;
  logic               w_pop_ok;
  logic               w_drop;
  logic [ENTRY_W-1:0] w_head;
  logic [CNT_W-1:0]   w_count;
  logic [CNT_W-1:0]   w_count_after;
  logic               w_full;
  logic               w_empty;
  logic [7:0]         w_flags;
  logic [ENT_W-1:0]   w_entry;

  // A fall only counts once a real high cs_n has been seen after reset, so a
  // cs_n held low through reset release never starts a frame.
  assign w_cs_fall = r_armed & r_cs_d & ~r_cs_sync2;

  // cs_n synchronizer, arming and registered falling-edge detect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cs_sync1 <= 1'b1;
      r_cs_sync2 <= 1'b1;
      r_cs_d     <= 1'b1;
      r_fill     <= 2'b00;
      r_armed    <= 1'b0;
      r_frame    <= 1'b0;
    end else begin
      r_cs_sync1 <= bus.cs_n;
      r_cs_sync2 <= r_cs_sync1;
      r_cs_d     <= r_cs_sync2;
      r_fill     <= {r_fill[0], 1'b1};
      r_armed    <= r_armed | (r_fill[1] & r_cs_sync2);
      r_frame    <= w_cs_fall;
    end
  end

  assign w_irq_rise = bus.irq & ~r_irq_d;
  assign w_push_req = w_irq_rise & ~w_dup;
  assign w_pop_ok   = r_frame & ~w_empty;
  assign w_push_ok  = w_push_req & (~w_full | w_pop_ok);
  assign w_drop     = w_push_req & ~w_push_ok;

`ifdef NONCE_DEDUP_EN
  logic [ENTRY_W-1:0] r_last;
  logic               r_last_vld;

  assign w_dup = r_last_vld && (bus.id_nonce_in == r_last);

  // Remember the last entry actually written; the valid bit lets an
  // all-zero first entry through once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last     <= '0;
      r_last_vld <= 1'b0;
    end else if (w_push_ok) begin
      r_last     <= bus.id_nonce_in;
      r_last_vld <= 1'b1;
    end
  end
`else
  assign w_dup = 1'b0;
`endif

  report_fifo #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push_req),
    .i_din   (bus.id_nonce_in),
    .i_pop   (r_frame),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Flag byte and entry field for the word being loaded this cycle
  always_comb begin
    w_flags            = '0;
    w_flags[FLG_VALID] = ~w_empty;
    w_flags[FLG_OVF]   = r_overflow;
    w_flags[FLG_BUSY]  = bus.busy_in;
    w_entry            = w_empty ? '0 : ENT_W'(w_head);
    w_count_after      = w_count - {{(CNT_W-1){1'b0}}, w_pop_ok};
  end

  // irq edge history, sticky overflow (set wins over frame clear), word load
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_d    <= 1'b0;
      r_overflow <= 1'b0;
      r_miso     <= '0;
    end else begin
      r_irq_d    <= bus.irq;
      r_overflow <= w_drop | (r_overflow & ~r_frame);
      if (r_frame)
        r_miso <= pack_word(8'(w_count_after), w_flags, w_entry, bus.hash_dify_in);
    end
  end

  assign bus.miso_data = r_miso;
  assign bus.count     = w_count;
  assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_nonce_report_queue.sv
// Scoreboard bench for nonce_report_queue: stimulus queues expected results,
// a monitor pops them on each frame load or status poll and compares.
module tb_nonce_report_queue;

  localparam int K_FRAME = 0;
  localparam int K_STAT  = 1;
  localparam int K_WORD  = 2;

  typedef struct {
    int           kind;
    string        name;
    logic [359:0] word;
    int           cnt;
    logic         ovf;
  } exp_t;

  logic clk;
  logic reset_n;
  logic chk_req;
  int   n_checks;
  int   n_pass;
  exp_t exp_q[$];

  logic [39:0] ent [0:10];
  logic [31:0] dify;
  int          cur_cnt;

  nonce_report_queue_if #(.DEPTH(8), .ENTRY_W(40)) bus ();

  nonce_report_queue #(.DEPTH(8), .ENTRY_W(40)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [359:0] mk_word(input int cnt, input bit valid, input bit ovf,
                                           input bit busy, input logic [39:0] e,
                                           input logic [31:0] d);
    logic [7:0] c;
    c = cnt[7:0];
    return {8'hA5, c, 5'b00000, busy, ovf, valid, e, d, 264'b0};
  endfunction

  task automatic do_check(input int trig);
    exp_t e;
    bit   ok;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_event trig=%0d: actual=event required=no event", trig);
      return;
    end
    e = exp_q.pop_front();
    if ((trig == K_FRAME) != (e.kind == K_FRAME)) begin
      $display("FAIL %s: actual trigger=%0d required kind=%0d", e.name, trig, e.kind);
      return;
    end
    if (e.kind == K_STAT) begin
      ok = (int'(bus.count) == e.cnt) && (bus.overflow === e.ovf);
      if (ok) begin
        n_pass++;
        $display("ok   %s count=%0d overflow=%0b", e.name, bus.count, bus.overflow);
      end else
        $display("FAIL %s: actual count=%0d overflow=%0b required count=%0d overflow=%0b",
                 e.name, bus.count, bus.overflow, e.cnt, e.ovf);
    end else begin
      ok = (bus.miso_data === e.word);
      if (ok) begin
        n_pass++;
        $display("ok   %s miso[359:264]=%h", e.name, bus.miso_data[359:264]);
      end else
        $display("FAIL %s: actual miso=%h required miso=%h", e.name, bus.miso_data, e.word);
    end
  endtask

  // Monitor: a cs_n fall means a frame word is due 3 edges after it is seen
  initial begin
    logic prev_cs;
    prev_cs = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (prev_cs && !bus.cs_n) begin
        repeat (3) @(posedge clk);
        #1;
        do_check(K_FRAME);
      end else if (chk_req) begin
        do_check(K_STAT);
      end
      prev_cs = bus.cs_n;
    end
  end

  task automatic poll(input exp_t e);
    exp_q.push_back(e);
    @(negedge clk);
    chk_req = 1'b1;
    @(negedge clk);
    chk_req = 1'b0;
  endtask

  task automatic check_stat(input string nm, input int cnt, input bit ovf);
    exp_t e;
    e.kind = K_STAT; e.name = nm; e.word = '0; e.cnt = cnt; e.ovf = ovf;
    poll(e);
  endtask

  task automatic check_word(input string nm, input logic [359:0] w);
    exp_t e;
    e.kind = K_WORD; e.name = nm; e.word = w; e.cnt = 0; e.ovf = 1'b0;
    poll(e);
  endtask

  task automatic push_entry(input logic [39:0] v, input int hold);
    @(negedge clk);
    bus.irq = 1'b1;
    bus.id_nonce_in = v;
    repeat (hold) @(negedge clk);
    bus.irq = 1'b0;
    @(negedge clk);
  endtask

  task automatic frame(input string nm, input logic [359:0] w, input bit push_too,
                       input logic [39:0] pv);
    exp_t e;
    e.kind = K_FRAME; e.name = nm; e.word = w; e.cnt = 0; e.ovf = 1'b0;
    exp_q.push_back(e);
    @(negedge clk);
    bus.cs_n = 1'b0;
    repeat (3) @(negedge clk);
    if (push_too) begin
      bus.irq = 1'b1;
      bus.id_nonce_in = pv;
    end
    @(negedge clk);
    bus.irq = 1'b0;
    repeat (2) @(negedge clk);
    bus.cs_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] drain_ent [0:7];
    logic [39:0] dd;
    n_checks = 0;
    n_pass   = 0;
    chk_req  = 1'b0;
    dify     = 32'h1234_5678;
    for (int i = 0; i < 11; i++) ent[i] = {8'h10 + 8'(i), 32'hC0DE_0000 + 32'(i)};
    reset_n          = 1'b0;
    bus.cs_n         = 1'b1;
    bus.irq          = 1'b0;
    bus.id_nonce_in  = '0;
    bus.hash_dify_in = dify;
    bus.busy_in      = 1'b1;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    check_stat("reset_state", 0, 1'b0);
    check_word("reset_miso", '0);
    frame("empty_frame", mk_word(0, 0, 0, 1, 40'h0, dify), 1'b0, '0);

    push_entry(40'h01_DEADBEEF, 10);
    check_stat("held_irq_one_push", 1, 1'b0);
    bus.busy_in = 1'b0;
    frame("first_entry", mk_word(0, 1, 0, 0, 40'h01_DEADBEEF, dify), 1'b0, '0);
    check_stat("after_pop", 0, 1'b0);

    for (int i = 0; i < 9; i++) push_entry(ent[i], 1);
    check_stat("full_overflow", 8, 1'b1);
    bus.busy_in = 1'b1;
    frame("ovf_frame", mk_word(7, 1, 1, 1, ent[0], dify), 1'b0, '0);
    check_stat("ovf_cleared", 7, 1'b0);
    push_entry(ent[9], 1);
    check_stat("refill", 8, 1'b0);
    frame("full_push_pop", mk_word(7, 1, 0, 1, ent[1], dify), 1'b1, ent[10]);
    check_stat("full_push_pop_stat", 8, 1'b0);

    dify = 32'hCAFE_F00D;
    bus.hash_dify_in = dify;
    drain_ent[0] = ent[2]; drain_ent[1] = ent[3]; drain_ent[2] = ent[4];
    drain_ent[3] = ent[5]; drain_ent[4] = ent[6]; drain_ent[5] = ent[7];
    drain_ent[6] = ent[9]; drain_ent[7] = ent[10];
    for (int i = 0; i < 8; i++)
      frame($sformatf("drain_%0d", i), mk_word(7 - i, 1, 0, 1, drain_ent[i], dify), 1'b0, '0);
    frame("drained_empty", mk_word(0, 0, 0, 1, 40'h0, dify), 1'b0, '0);

    dd = 40'h02_00000055;
    push_entry(dd, 1);
    push_entry(dd, 1);
`ifdef NONCE_DEDUP_EN
    cur_cnt = 1;
`else
    cur_cnt = 2;
`endif
    check_stat("dedup_pair", cur_cnt, 1'b0);
    for (int i = cur_cnt; i < 3; i++) push_entry(ent[i], 1);
    check_stat("three_entries", 3, 1'b0);

    // cs_n falls, then reset hits before the synced edge; release with cs_n low
    begin
      exp_t e;
      e.kind = K_FRAME; e.name = "reset_mid_frame"; e.word = '0; e.cnt = 0; e.ovf = 1'b0;
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.cs_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    repeat (6) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    check_stat("reset_flush", 0, 1'b0);
    check_word("no_load_low_cs", '0);
    bus.cs_n = 1'b1;
    repeat (4) @(negedge clk);
    frame("post_reset_frame", mk_word(0, 0, 0, 1, 40'h0, dify), 1'b0, '0);

    repeat (10) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0)
      $display("FAIL scoreboard_drain: actual pending=%0d required pending=0", exp_q.size());
    else
      n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
